// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver: synchronised and debounced PS/2 lines, frame decoder,
// scancode FIFO and a small Wishbone register file (DATA, STATUS, CTRL).
module ps2_keyboard_fifo #(
  parameter int FIFO_DEPTH      = 8,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic        irq_o
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Line conditioning: index 0 is PS2_CLK, index 1 is PS2_DATA
  logic [1:0]     r_sync0, r_sync1, r_filt;
  logic [DBW-1:0] r_dbc [2];
  logic           r_clk_d;

  // Frame decoder
  state_t         r_state, w_state_nxt;
  logic [2:0]     r_bitcnt;
  logic [TOW-1:0] r_tocnt;
  logic [7:0]     r_shift;
  logic           r_parbit;
  logic           r_push;
  logic [7:0]     r_push_byte;

  // FIFO and registers
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_ovf, r_perr, r_ferr;
  logic           r_en, r_irq_en;
  logic           r_ack, r_err, r_irq;
  logic [31:0]    r_dat_o;

  logic           w_strike, w_ps2d, w_to_hit, w_to_abort;
  logic           w_stop_strike, w_timeout, w_par_ok, w_stop_ok;
  logic           w_access, w_rd, w_wr;
  logic [1:0]     w_off;
  logic           w_empty, w_full, w_pop, w_push, w_push_try, w_flush;
  logic           w_ovf_set, w_perr_set, w_ferr_set, w_clr_status;
  logic [31:0]    w_rdata;
  logic           w_unused;

  assign w_unused = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:5]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sync0  <= 2'b11;
      r_sync1  <= 2'b11;
      r_filt   <= 2'b11;
      r_dbc[0] <= '0;
      r_dbc[1] <= '0;
      r_clk_d  <= 1'b1;
    end else begin
      r_sync0 <= {PS2_DATA, PS2_CLK};
      r_sync1 <= r_sync0;
      for (int i = 0; i < 2; i++) begin
        if (r_sync1[i] == r_filt[i]) begin
          r_dbc[i] <= '0;
        end else if (r_dbc[i] == DB_LAST) begin
          r_filt[i] <= r_sync1[i];
          r_dbc[i]  <= '0;
        end else begin
          r_dbc[i] <= r_dbc[i] + 1'b1;
        end
      end
      r_clk_d <= r_filt[0];
    end
  end

  assign w_strike   = r_clk_d & ~r_filt[0];
  assign w_ps2d     = r_filt[1];
  assign w_to_hit   = (r_tocnt == TO_LAST);
  assign w_to_abort = (r_state != S_IDLE) & ~w_strike & w_to_hit;
  assign w_par_ok   = ^{r_shift, r_parbit};
  assign w_stop_ok  = w_ps2d;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_stop_strike = 1'b0;
    w_timeout     = 1'b0;
    if (!r_en) begin
      w_state_nxt = S_IDLE;
    end else if (w_to_abort) begin
      w_state_nxt = S_IDLE;
      w_timeout   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE:   if (w_strike && !w_ps2d) w_state_nxt = S_DATA;
        S_DATA:   if (w_strike && r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: if (w_strike) w_state_nxt = S_STOP;
        S_STOP: begin
          if (w_strike) begin
            w_state_nxt   = S_IDLE;
            w_stop_strike = 1'b1;
          end
        end
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_bitcnt <= '0;
      r_tocnt  <= '0;
      r_push   <= 1'b0;
    end else begin
      if (r_state != S_DATA)  r_bitcnt <= '0;
      else if (w_strike)      r_bitcnt <= r_bitcnt + 1'b1;
      if (w_state_nxt == S_IDLE || w_strike) r_tocnt <= '0;
      else                                   r_tocnt <= r_tocnt + 1'b1;
      r_push <= w_stop_strike & w_par_ok & w_stop_ok;
    end
  end

  // Frame payload carries no reset; the control path decides when it is used
  always_ff @(posedge wb_clk_i) begin
    if (w_strike && r_state == S_DATA)   r_shift  <= {w_ps2d, r_shift[7:1]};
    if (w_strike && r_state == S_PARITY) r_parbit <= w_ps2d;
    r_push_byte <= r_shift;
  end

  assign w_access     = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_off        = wb_adr_i[3:2];
  assign w_rd         = w_access & ~wb_we_i;
  assign w_wr         = w_access & wb_we_i;
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == DEPTH_C);
  assign w_pop        = w_rd & (w_off == 2'd0) & ~w_empty;
  assign w_flush      = w_wr & (w_off == 2'd2) & wb_dat_i[2];
  assign w_push_try   = r_push & r_en;
  assign w_push       = w_push_try & (~w_full | w_pop);
  assign w_ovf_set    = w_push_try & w_full & ~w_pop;
  assign w_perr_set   = w_stop_strike & ~w_par_ok;
  assign w_ferr_set   = (w_stop_strike & ~w_stop_ok) | w_timeout;
  assign w_clr_status = w_wr & (w_off == 2'd1);

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wptr] <= r_push_byte;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ovf    <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_en     <= 1'b1;
      r_irq_en <= 1'b0;
    end else begin
      r_ovf  <= w_ovf_set  | (r_ovf  & ~(w_clr_status & wb_dat_i[2]));
      r_perr <= w_perr_set | (r_perr & ~(w_clr_status & wb_dat_i[3]));
      r_ferr <= w_ferr_set | (r_ferr & ~(w_clr_status & wb_dat_i[4]));
      if (w_wr && w_off == 2'd2) begin
        r_en     <= wb_dat_i[0];
        r_irq_en <= wb_dat_i[1];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      2'd0: if (!w_empty) w_rdata = {23'b0, 1'b1, r_mem[r_rptr]};
      2'd1: w_rdata = {16'b0, 8'(r_count), 3'b0, r_ferr, r_perr, r_ovf, w_full, ~w_empty};
      2'd2: w_rdata = {30'b0, r_irq_en, r_en};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_ack   <= w_access & (w_off != 2'd3);
      r_err   <= w_access & (w_off == 2'd3);
      r_dat_o <= (w_rd && w_off != 2'd3) ? w_rdata : 32'd0;
      r_irq   <= r_irq_en & ~w_empty;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_dat_o = r_dat_o;
  assign irq_o    = r_irq;

endmodule
